// File: rtl/imem_loader.sv
// Instruction-memory programmer: packs a little-endian byte stream into 32-bit words,
// writes them from address 0, then reads them back and compares XOR checksums.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_VERIFY, S_CHECK, S_FINISH
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     ww_q;
  logic [ADDR_W:0]     ww_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   last_addr_d;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   word_d;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   wr_xor_q;
  logic [DATA_W-1:0]   rd_xor_q;
  logic [1:0]          byte_idx_q;
  logic                in_ready_q;
  logic                wren_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                count_ok_d;

  always_comb begin
    ww_d        = ww_q + (ADDR_W+1)'(1);
    last_addr_d = ADDR_W'(cnt_q - (ADDR_W+1)'(1));
    count_ok_d  = (word_count != '0) && (word_count <= MAX_COUNT);
    word_d      = word_q;
    word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ww_q       <= '0;
      byte_idx_q <= '0;
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            ww_q     <= '0;
            wr_xor_q <= '0;
            rd_xor_q <= '0;
            if (count_ok_d) begin
              cnt_q      <= word_count;
              addr_q     <= '0;
              byte_idx_q <= '0;
              error_q    <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= S_COLLECT;
            end else begin
              // Unusable count: report through FINISH without touching memory.
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_COLLECT: begin
          if (in_valid && in_ready_q) begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wdata_q    <= word_d;
              wren_q     <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wr_xor_q <= wr_xor_q ^ wdata_q;
          ww_q     <= ww_d;
          if (ww_d == cnt_q) begin
            addr_q  <= '0;
            state_q <= S_VERIFY;
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= S_COLLECT;
          end
        end
        S_VERIFY: begin
          // mem_q lags the address by one cycle, so address 0 has no data yet.
          if (addr_q != '0) rd_xor_q <= rd_xor_q ^ mem_q;
          if (addr_q == last_addr_d) begin
            state_q <= S_CHECK;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_CHECK: begin
          rd_xor_q <= rd_xor_q ^ mem_q;
          done_q   <= 1'b1;
          state_q  <= S_FINISH;
        end
        S_FINISH: begin
          if (rd_xor_q != wr_xor_q) error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_addr      = addr_q;
  assign mem_data      = wdata_q;
  assign mem_wren      = wren_q;
  assign busy          = busy_q;
  assign cpu_hold      = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a transaction-level model predicts the write order,
// readback sweep, done timing and error flag; the bench also owns the instruction memory.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, fault;
  logic [8:0]  word_count;
  logic [7:0]  in_data;
  logic        in_ready, mem_wren, busy, cpu_hold, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data, mem_q;
  logic [8:0]  words_written;

  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_written(words_written)
  );

  // Instruction memory: one-cycle read latency, optional corruption of address 1 on readback.
  logic [31:0] mem_arr [0:255];
  always @(posedge clk) begin
    if (mem_wren) mem_arr[mem_addr] <= mem_data;
    mem_q <= (fault && mem_addr == 8'd1) ? 32'h0 : mem_arr[mem_addr];
  end

  int checks = 0, errs = 0, cyc = 0;
  logic [31:0] e_data [0:255];
  int m_n = 0, m_wr = 0, m_vidx = -1, done_cyc = 0, done_evt = 0, start_cyc = 0;
  bit m_busy = 0, m_err = 0, m_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic cycle_check();
    chk("cpu_hold", 32'(cpu_hold), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_vidx == m_n + 1));
    chk("error", 32'(error), 32'(m_err));
    chk("words_written", 32'(words_written), 32'(m_wr));
    if (!m_busy || mem_wren || m_vidx >= 0) chk("in_ready_low", 32'(in_ready), 32'd0);
    if (mem_wren) begin
      if (m_wr >= m_n) chk("unexpected_wren", 32'(mem_wren), 32'd0);
      else begin
        chk("wr_addr", 32'(mem_addr), 32'(m_wr));
        chk("wr_data", mem_data, e_data[m_wr]);
        m_wr++;
        if (m_wr == m_n) m_vidx = 0;
      end
    end else if (m_vidx >= 0 && m_vidx < m_n) begin
      chk("rd_addr", 32'(mem_addr), 32'(m_vidx));
      m_vidx++;
    end else if (m_vidx == m_n) begin
      m_vidx++;
    end else if (m_vidx == m_n + 1) begin
      done_cyc = cyc;
      done_evt++;
      m_vidx = -1;
      m_busy = 0;
      m_err  = m_fail;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    cycle_check();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    at_neg();
    to_pos();
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, mem_data, 32'd0);
    chk({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_wr = 0; m_vidx = -1; m_err = 0; m_fail = 0;
  endtask

  task automatic do_start(input int cnt);
    int s = cyc;
    logic [31:0] wx, rx;
    start = 1'b1;
    word_count = 9'(cnt);
    step();
    start = 1'b0;
    if (!m_busy) begin
      m_busy = 1; m_wr = 0; start_cyc = s;
      if (cnt < 1 || cnt > 256) begin
        m_n = 0; m_vidx = 1; m_err = 1; m_fail = 1;
      end else begin
        m_n = cnt; m_vidx = -1; m_err = 0;
        wx = 32'h0; rx = 32'h0;
        for (int k = 0; k < cnt; k++) begin
          wx ^= e_data[k];
          rx ^= (fault && k == 1) ? 32'h0 : e_data[k];
        end
        m_fail = (wx != rx);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 40 && !acc; t++) begin
      at_neg();
      acc = in_ready;
      to_pos();
    end
    in_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input int n, input bit stall);
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++) begin
        send_byte(e_data[k][8*b +: 8]);
        if (stall) step();
      end
  endtask

  task automatic wait_done();
    int ev = done_evt;
    for (int t = 0; t < 4000 && done_evt == ev; t++) step();
    if (done_evt == ev) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h0; word_count = 9'h0; fault = 1'b0;
    to_pos();
    at_neg();
    reset_lits("rst");
    to_pos();
    rst = 1'b1;

    // Single word, explicit little-endian bytes.
    e_data[0] = 32'h12345678;
    do_start(1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    wait_done();
    chk("t1_done_cycle", 32'(done_cyc), 32'(start_cyc + 8));
    chk("t1_mem0", mem_arr[0], 32'h12345678);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_words", 32'(words_written), 32'd1);

    // Stalled stream: a bubble after every byte.
    e_data[0] = 32'hDEADBEEF; e_data[1] = 32'h00000001;
    do_start(2);
    load(2, 1'b1);
    wait_done();
    chk("t2_mem0", mem_arr[0], 32'hDEADBEEF);
    chk("t2_mem1", mem_arr[1], 32'h00000001);
    chk("t2_error", 32'(error), 32'd0);

    // Full 256-word load.
    for (int k = 0; k < 256; k++) e_data[k] = 32'(k);
    do_start(256);
    load(256, 1'b0);
    wait_done();
    chk("t3_done_cycle", 32'(done_cyc), 32'(start_cyc + 6 * 256 + 2));
    chk("t3_error", 32'(error), 32'd0);
    chk("t3_words", 32'(words_written), 32'd256);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem_arr[k] !== 32'(k)) bad++;
    chk("t3_mem_contents", 32'(bad), 32'd0);

    // Readback of address 1 corrupted.
    fault = 1'b1;
    e_data[0] = 32'h11111111; e_data[1] = 32'h22222222;
    do_start(2);
    load(2, 1'b0);
    wait_done();
    repeat (3) step();
    chk("t4_error_sticky", 32'(error), 32'd1);
    fault = 1'b0;

    // Bad counts.
    do_start(0);
    wait_done();
    chk("t5_zero_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
    chk("t5_zero_error", 32'(error), 32'd1);
    do_start(300);
    wait_done();
    chk("t5_big_error", 32'(error), 32'd1);

    // Start pulses during COLLECT are ignored.
    e_data[0] = 32'hA5A50F0F; e_data[1] = 32'h80000001;
    do_start(2);
    send_byte(8'h0F); send_byte(8'h0F);
    do_start(0);
    do_start(3);
    send_byte(8'hA5); send_byte(8'hA5);
    for (int b = 0; b < 4; b++) send_byte(e_data[1][8*b +: 8]);
    wait_done();
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_words", 32'(words_written), 32'd2);
    chk("t6_mem0", mem_arr[0], 32'hA5A50F0F);

    // Reset after two bytes of word 3, then a fresh one-word load.
    for (int k = 0; k < 5; k++) e_data[k] = 32'h10000000 + 32'(k);
    do_start(5);
    load(3, 1'b0);
    send_byte(e_data[3][7:0]);
    send_byte(e_data[3][15:8]);
    rst = 1'b0;
    step();
    model_reset();
    at_neg();
    reset_lits("midrst");
    to_pos();
    rst = 1'b1;
    e_data[0] = 32'hCAFEF00D;
    do_start(1);
    load(1, 1'b0);
    wait_done();
    chk("t7_mem0", mem_arr[0], 32'hCAFEF00D);
    chk("t7_error", 32'(error), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side programmer for the 256 x 32-bit instruction memory. Accepts a little-endian byte stream (e.g. from a host/UART receiver) and assembles each group of four bytes into an instruction word. Writes the words sequentially from address 0 through the memory's `address`/`data`/`wren` port, then reads every word back and compares checksums. While loading it holds the CPU core in reset through `cpu_hold`.

## Interface

Parameters:
- `ADDR_W`, 8: memory address width (depth 2^ADDR_W words).
- `DATA_W`, 32: instruction word width; must be 32 (4 bytes).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to load (1..256); sampled on an accepted `start`.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_data`  out  32  memory write data.
- `mem_wren`  out  1  memory write enable.
- `mem_q`  in  32  memory read data, valid one cycle after its address is presented.
- `busy`  out  1  high from an accepted `start` until the end of FINISH.
- `cpu_hold`  out  1  equal to `busy`.
- `done`  out  1  one-cycle pulse in FINISH.
- `error`  out  1  sticky verify-failure or bad-count flag; cleared by the next accepted `start`.
- `words_written`  out  ADDR_W+1  words committed so far in the current load.

## Operation

States are IDLE, COLLECT, WRITE, VERIFY, CHECK and FINISH.

- **IDLE**
  - `in_ready`=0.
  - On `start` with `word_count` in 1..256:
    - latch the count;
    - clear the write address, `words_written`, `wr_xor`, `rd_xor`, the byte index and `error`;
    - go to COLLECT.
  - On `start` with `word_count` of 0 or greater than 256: set `error`=1 and go to FINISH with no memory access.
- **COLLECT**
  - `in_ready`=1.
  - Each accepted byte goes into the word buffer at lane `byte_idx` (the first byte is bits 7:0, the fourth is bits 31:24).
  - `byte_idx` increments modulo 4.
  - On acceptance of the 4th byte, go to WRITE.
  - `in_valid` while `in_ready`=0 is never consumed.
- **WRITE** (exactly one cycle)
  - `in_ready`=0, `mem_wren`=1, `mem_addr`=write address, `mem_data`=assembled word.
  - `wr_xor` ^= word; `words_written`++.
  - If the new `words_written` equals the count: zero `mem_addr` and go to VERIFY. Otherwise increment the address and return to COLLECT.
- **VERIFY**
  - `mem_wren`=0.
  - Present read addresses 0..count-1, one per cycle.
  - From the second VERIFY cycle onward, `rd_xor` ^= `mem_q`.
  - After presenting address count-1, go to CHECK.
- **CHECK** (one cycle)
  - `rd_xor` ^= `mem_q`, which is the last word.
- **FINISH** (one cycle)
  - `done`=1.
  - If `rd_xor` != `wr_xor`, set `error`=1.
  - Go to IDLE; `busy` deasserts on the next cycle.

Boundary and concurrent conditions:
- `start` while busy is ignored.
- A count of 256 fills the memory, and the address wraps to 0 only through the explicit clear before VERIFY.
- The byte stream may stall indefinitely; there is no timeout.
- Reset mid-load returns to IDLE at once. Memory contents already written stay undefined to the CPU; the host must reload.

## Timing

- Reset values:
  - `mem_addr`=0, `mem_data`=0, `mem_wren`=0;
  - `in_ready`=0, `busy`=0, `cpu_hold`=0, `done`=0, `error`=0, `words_written`=0;
  - state IDLE.
- `busy` and `cpu_hold` rise the cycle after an accepted `start`.
- With back-to-back bytes, each word costs 5 cycles (4 COLLECT + 1 WRITE). The 4th byte's acceptance edge is followed by `mem_wren` high for exactly one cycle.
- VERIFY lasts N cycles, then CHECK 1 cycle and FINISH 1 cycle.
- Minimum total from `start` to `done` is 1 + 5N + N + 2 cycles.
- `mem_wren` is never high outside WRITE.

## Test plan

- **Single word:** reset low 2 cycles, `start` with `word_count`=1, bytes 0x78,0x56,0x34,0x12 back-to-back.
  - One write: `mem_addr`=0, `mem_data`=0x12345678.
  - `done` 2 cycles after the single VERIFY cycle; `error`=0; `words_written`=1.
- **Full load:** `word_count`=256 with word k = {24'h0, k}.
  - 256 writes at addresses 0..255.
  - Readback via `mem_q` matches; `error`=0; `cpu_hold` is high throughout.
- **Stalled stream:** `word_count`=2, `in_valid` toggling every other cycle.
  - Words 0xDEADBEEF and 0x00000001 written to addresses 0 and 1.
  - No byte lost or duplicated.
- **Verify failure:** memory model forces the readback of address 1 to be 0.
  - `done` pulses; `error`=1 and stays 1 until the next `start`.
- **Bad count and ignored start:**
  - `word_count`=0 gives `error`=1 and `done` with no `mem_wren`.
  - A `start` pulse during COLLECT changes nothing.
- **Reset mid-operation:** `rst` low after 2 bytes of word 3.
  - Next cycle: all outputs at reset values.
  - A subsequent load of 1 word writes address 0.
